ts_switch_sequencer: RTL and testbench
======================================

Name: ts_switch_sequencer

Overview:
- Packet-aligned switchover controller for the 4-channel TS output mux.
- Takes the requested channel and enable from main_control (mux_control / en_mux) and drives the mux select and output gate.
- Switches only at 188-byte packet boundaries, so no partial packet reaches the output.
- Provides a bounded-time fallback (timeout) and status counters for the memory-mapped register block.

Parameters:
- TMO_W, 16, width of the timeout counter and cfg_timeout.
- CNT_W, 16, width of the switch_count status counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low (rst=0 resets on the rising edge of clk).
- req_ch  in  2  requested channel (from main_control mux_control).
- req_en  in  1  output enable request (from main_control en_mux).
- byte_valid  in  4  per-channel byte strobe; bit n = channel n.
- sof  in  4  per-channel start-of-packet (sync byte 0x47); qualified by byte_valid[n].
- cfg_timeout  in  TMO_W  maximum cycles allowed in DRAIN/ALIGN; 0 disables the timeout.
- clr_status  in  1  single-cycle pulse; clears switch_count and timeout_flag.
- sel_ch  out  2  registered mux select.
- gate  out  1  registered output gate; 1 = mux output passed downstream.
- busy  out  1  1 while in DRAIN or ALIGN.
- state  out  2  IDLE=00, ACTIVE=01, DRAIN=10, ALIGN=11.
- switch_count  out  CNT_W  completed switches; saturates at all-ones.
- timeout_flag  out  1  sticky; set on any timeout.

Behaviour:
- Timing contract: sof/byte_valid arrive one clock ahead of the corresponding data byte at the mux (the datapath has a 1-stage delay). Registered sel_ch/gate updated on the edge after an event therefore align with that byte.
- Reset (rst=0): state=IDLE, sel_ch=0, gate=0, busy=0, switch_count=0, timeout_flag=0, target=0, timer=0.
- Define sofq[n] = sof[n] & byte_valid[n].
- Target register: loaded with req_ch every cycle while in DRAIN or ALIGN.
- IDLE: gate=0. If req_en=1, go to ALIGN with target=req_ch.
- ACTIVE: gate=1.
  - If req_en=0, go to DRAIN in disable mode.
  - Else if req_ch != sel_ch, go to DRAIN with target=req_ch.
  - Otherwise stay.
- DRAIN (gate stays 1):
  - Cancel: if req_en=1 and req_ch==sel_ch, return to ACTIVE with no gate glitch and no count.
  - On sofq[sel_ch] (the old packet ends):
    - Disable mode: gate<=0, go to IDLE.
    - Else if sofq[target] in the same cycle (hitless case): sel_ch<=target, gate stays 1, switch_count++, go to ACTIVE.
    - Else: gate<=0, go to ALIGN.
  - Cancel has priority over a same-cycle sofq.
- ALIGN (gate=0):
  - If req_en=0, go to IDLE.
  - On sofq[req_ch]: sel_ch<=req_ch, gate<=1, switch_count++, go to ACTIVE.
- Timer:
  - Cleared on every entry to DRAIN or ALIGN; increments each cycle in those states.
  - When timer==cfg_timeout-1 and cfg_timeout!=0, a timeout fires:
    - In DRAIN: gate<=0, timeout_flag<=1, go to ALIGN (or IDLE in disable mode). This is a forced truncation.
    - In ALIGN: timeout_flag<=1, timer restarts, stay in ALIGN.
  - A real sofq event in the same cycle takes priority over the timeout.
- Mode latching: disable mode is latched at DRAIN entry. A later req_en=1 in DRAIN with req_ch!=sel_ch converts DRAIN to switch mode.
- clr_status:
  - Clear has priority over a same-cycle increment or flag set (result: count=0, flag=0).
  - switch_count holds at all-ones once saturated.
- busy = (state==DRAIN or state==ALIGN), registered with state.
- Reset mid-switch: immediate return to IDLE with gate=0; no count increment.

Test Plan:
- Enable from IDLE: release rst, req_en=1, req_ch=2, sofq[2] at cycle 10 -> state ALIGN then ACTIVE; sel_ch=2 and gate=1 on the edge after cycle 10; switch_count=1.
- Switch ch2->ch1 with sofq[2] at cycle 100 and sofq[1] at cycle 150 -> gate=0 from cycle 101; sel_ch=1 and gate=1 from cycle 151; switch_count=2; busy high for cycles 1..150 of the switch.
- Hitless: sofq[2] and sofq[1] in the same cycle during DRAIN -> gate never drops; sel_ch changes 2->1 on the next edge; count increments.
- Cancel: in DRAIN, req_ch returns to 2 before any sofq -> back to ACTIVE; gate stays 1; count unchanged.
- Timeout: cfg_timeout=30, no sofq on the old channel -> after 30 DRAIN cycles gate=0, timeout_flag=1, state ALIGN; clr_status pulse -> flag=0, count=0.
- Disable and reset: req_en=0 in ACTIVE -> gate drops on the edge after sofq[sel_ch], state IDLE. Asserting rst=0 during ALIGN -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/ts_switch_sequencer_if.sv
// ts_switch_sequencer_if: channel request, packet strobes, mux controls and status of the switch sequencer
interface ts_switch_sequencer_if #(
  parameter int TMO_W = 16,
  parameter int CNT_W = 16
);
  logic [1:0]       req_ch;
  logic             req_en;
  logic [3:0]       byte_valid;
  logic [3:0]       sof;
  logic [TMO_W-1:0] cfg_timeout;
  logic             clr_status;
  logic [1:0]       sel_ch;
  logic             gate;
  logic             busy;
  logic [1:0]       state;
  logic [CNT_W-1:0] switch_count;
  logic             timeout_flag;
  modport master (
    output req_ch, req_en, byte_valid, sof, cfg_timeout, clr_status,
    input  sel_ch, gate, busy, state, switch_count, timeout_flag
  );
  modport slave (
    input  req_ch, req_en, byte_valid, sof, cfg_timeout, clr_status,
    output sel_ch, gate, busy, state, switch_count, timeout_flag
  );
endinterface

// File: rtl/ts_switch_sequencer.sv
// ts_switch_sequencer: packet-aligned switchover of the 4-channel TS output mux with timeout fallback
module ts_switch_sequencer #(
  parameter int TMO_W = 16,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  ts_switch_sequencer_if.slave io
);
  localparam logic [1:0] IDLE = 2'b00, ACTIVE = 2'b01, DRAIN = 2'b10, ALIGN = 2'b11;
  logic [1:0]       state_q, state_d, sel_q, sel_d, tgt_q, tgt_d;
  logic             gate_q, busy_q, flag_q, dis_q, dis_d, inc, tmo_hit, tmo;
  logic [TMO_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       sofq;
  assign sofq = io.sof & io.byte_valid;
  assign tmo  = (io.cfg_timeout != '0) && (tmr_q == io.cfg_timeout - TMO_W'(1));
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    tgt_d   = state_q[1] ? io.req_ch : tgt_q;
    dis_d   = dis_q;
    inc     = 1'b0;
    tmo_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (io.req_en) begin
          state_d = ALIGN;
          tgt_d   = io.req_ch;
        end
      end
      ACTIVE: begin
        if (!io.req_en || io.req_ch != sel_q) begin
          state_d = DRAIN;
          dis_d   = !io.req_en;
          tgt_d   = io.req_ch;
        end
      end
      DRAIN: begin
        // any enabled request in DRAIN leaves disable mode (same channel cancels below)
        if (io.req_en) dis_d = 1'b0;
        if (io.req_en && io.req_ch == sel_q) state_d = ACTIVE;
        else if (sofq[sel_q]) begin
          if (dis_d) state_d = IDLE;
          else if (sofq[tgt_q]) begin
            sel_d   = tgt_q;
            inc     = 1'b1;
            state_d = ACTIVE;
          end else state_d = ALIGN;
        end else if (tmo) begin
          tmo_hit = 1'b1;
          state_d = dis_d ? IDLE : ALIGN;
        end
      end
      default: begin
        if (!io.req_en) state_d = IDLE;
        else if (sofq[io.req_ch]) begin
          sel_d   = io.req_ch;
          inc     = 1'b1;
          state_d = ACTIVE;
        end else if (tmo) tmo_hit = 1'b1;
      end
    endcase
    tmr_d = (state_d[1] && (state_d != state_q || tmo_hit)) ? '0 :
            state_q[1] ? tmr_q + TMO_W'(1) : tmr_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      tgt_q   <= '0;
      dis_q   <= 1'b0;
      tmr_q   <= '0;
      gate_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      tgt_q   <= tgt_d;
      dis_q   <= dis_d;
      tmr_q   <= tmr_d;
      gate_q  <= state_d[0] ^ state_d[1];
      busy_q  <= state_d[1];
      cnt_q   <= io.clr_status ? '0 : (inc && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
      flag_q  <= io.clr_status ? 1'b0 : (flag_q | tmo_hit);
    end
  end
  assign io.sel_ch       = sel_q;
  assign io.gate         = gate_q;
  assign io.busy         = busy_q;
  assign io.state        = state_q;
  assign io.switch_count = cnt_q;
  assign io.timeout_flag = flag_q;
endmodule

// File: tb/tb_ts_switch_sequencer.sv
// tb_ts_switch_sequencer: directed scenarios checked every cycle against a behavioural model plus literal checkpoints
module tb_ts_switch_sequencer;
  localparam int TMO_W = 16, CNT_W = 16;
  localparam int S_IDLE = 0, S_ACTIVE = 1, S_DRAIN = 2, S_ALIGN = 3;
  localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  ts_switch_sequencer_if #(.TMO_W(TMO_W), .CNT_W(CNT_W)) bus ();
  ts_switch_sequencer #(.TMO_W(TMO_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .io(bus));
  int n_chk = 0, n_fail = 0;
  bit armed = 1'b0;
  int m_st = S_IDLE, m_tmr = 0;
  logic [1:0] m_sel = 2'd0, m_tgt = 2'd0;
  bit m_dis = 1'b0, m_flag = 1'b0;
  longint m_cnt = 0;
  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask
  // Model: gate is open exactly in ACTIVE and DRAIN, busy exactly in DRAIN and ALIGN
  always @(posedge clk) begin
    logic [3:0] q;
    bit fire, inc, to, en;
    logic [1:0] ch;
    int nxt;
    if (!rst) begin
      m_st = S_IDLE; m_sel = 0; m_tgt = 0; m_dis = 0; m_tmr = 0; m_cnt = 0; m_flag = 0;
    end else begin
      q = bus.sof & bus.byte_valid;
      en = bus.req_en;
      ch = bus.req_ch;
      fire = (bus.cfg_timeout != 0) && (m_tmr == int'(bus.cfg_timeout) - 1);
      inc = 0; to = 0; nxt = m_st;
      if (m_st == S_IDLE && en) begin
        nxt = S_ALIGN; m_tgt = ch;
      end else if (m_st == S_ACTIVE && (!en || ch != m_sel)) begin
        nxt = S_DRAIN; m_dis = !en; m_tgt = ch;
      end else if (m_st == S_DRAIN) begin
        if (en && ch != m_sel) m_dis = 0;
        if (en && ch == m_sel) nxt = S_ACTIVE;
        else if (q[m_sel]) begin
          if (m_dis) nxt = S_IDLE;
          else if (q[m_tgt]) begin m_sel = m_tgt; inc = 1; nxt = S_ACTIVE; end
          else nxt = S_ALIGN;
        end else if (fire) begin to = 1; nxt = m_dis ? S_IDLE : S_ALIGN; end
      end else if (m_st == S_ALIGN) begin
        if (!en) nxt = S_IDLE;
        else if (q[ch]) begin m_sel = ch; inc = 1; nxt = S_ACTIVE; end
        else if (fire) to = 1;
      end
      if (m_st >= S_DRAIN) m_tgt = ch;
      m_tmr = (m_st >= S_DRAIN && nxt == m_st && !to) ? m_tmr + 1 : 0;
      m_st = nxt;
      if (bus.clr_status) begin m_cnt = 0; m_flag = 0; end
      else begin
        if (inc && m_cnt < CNT_MAX) m_cnt++;
        if (to) m_flag = 1;
      end
    end
  end
  initial begin
    @(posedge clk);
    armed = 1'b1;
  end
  always @(negedge clk) begin
    if (armed) begin
      chk("state", bus.state, m_st);
      chk("sel_ch", bus.sel_ch, m_sel);
      chk("gate", bus.gate, (m_st == S_ACTIVE || m_st == S_DRAIN));
      chk("busy", bus.busy, (m_st >= S_DRAIN));
      chk("switch_count", bus.switch_count, m_cnt);
      chk("timeout_flag", bus.timeout_flag, m_flag);
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pkt(input logic [3:0] m);
    bus.sof = m;
    tick(1);
    bus.sof = 4'h0;
  endtask
  task automatic lit(input string nm, input int st, input int sel, input int g, input longint cnt, input int fl);
    #1;
    chk({nm, ".state"}, bus.state, st);
    chk({nm, ".sel_ch"}, bus.sel_ch, sel);
    chk({nm, ".gate"}, bus.gate, g);
    chk({nm, ".switch_count"}, bus.switch_count, cnt);
    chk({nm, ".timeout_flag"}, bus.timeout_flag, fl);
  endtask
  initial begin
    bus.req_en = 0; bus.req_ch = 0; bus.byte_valid = 4'hF; bus.sof = 0;
    bus.cfg_timeout = 0; bus.clr_status = 0;
    tick(2);
    lit("reset", 0, 0, 0, 0, 0);
    chk("reset.busy", bus.busy, 0);
    rst = 1; bus.req_en = 1; bus.req_ch = 2;
    tick(1);
    lit("enable_align", 3, 0, 0, 0, 0);
    bus.byte_valid = 4'hB; bus.sof = 4'h4;
    tick(1);
    bus.byte_valid = 4'hF; bus.sof = 0;
    lit("unqualified_sof", 3, 0, 0, 0, 0);
    tick(6);
    pkt(4'h4);
    lit("enable_done", 1, 2, 1, 1, 0);
    bus.req_ch = 1;
    tick(1);
    lit("switch_drain", 2, 2, 1, 1, 0);
    tick(5);
    pkt(4'h4);
    lit("switch_align", 3, 2, 0, 1, 0);
    tick(5);
    pkt(4'h2);
    lit("switch_done", 1, 1, 1, 2, 0);
    bus.req_ch = 2;
    tick(3);
    pkt(4'h6);
    lit("hitless", 1, 2, 1, 3, 0);
    bus.req_ch = 1;
    tick(4);
    bus.req_ch = 2;
    tick(1);
    lit("cancel", 1, 2, 1, 3, 0);
    bus.req_ch = 1;
    tick(1);
    bus.req_ch = 2;
    pkt(4'h6);
    lit("cancel_vs_sof", 1, 2, 1, 3, 0);
    bus.cfg_timeout = 30; bus.req_ch = 1;
    tick(30);
    lit("drain_before_timeout", 2, 2, 1, 3, 0);
    tick(1);
    lit("drain_timeout", 3, 2, 0, 3, 1);
    tick(40);
    lit("align_timeout", 3, 2, 0, 3, 1);
    bus.clr_status = 1;
    pkt(4'h2);
    bus.clr_status = 0;
    lit("clear_vs_inc", 1, 1, 1, 0, 0);
    bus.cfg_timeout = 0; bus.req_en = 0;
    tick(4);
    lit("disable_drain", 2, 1, 1, 0, 0);
    pkt(4'h2);
    lit("disable_idle", 0, 1, 0, 0, 0);
    bus.req_en = 1; bus.req_ch = 3;
    tick(3);
    rst = 0;
    tick(1);
    lit("reset_in_align", 0, 0, 0, 0, 0);
    chk("reset_in_align.busy", bus.busy, 0);
    rst = 1;
    tick(2);
    lit("realign", 3, 0, 0, 0, 0);
    tick(1);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
